// File: rtl/message_history.sv
// message_history: circular scrollback store of CHARS-byte strings presented as a VIEW-slot window, newest first
//   clk          system clock
//   reset        asynchronous active-high reset
//   push         1-cycle strobe, appends msg_in
//   msg_in       CHARS*8-bit string to append
//   clear        1-cycle strobe, empties the store (wins over push and scroll)
//   scroll_up    1-cycle strobe, view one entry older
//   scroll_down  1-cycle strobe, view one entry newer
//   window       VIEW slots of CHARS*8 bits, slot 0 in the low bits is the newest visible entry
//   count        valid entries held, 0..STORE
//   live         1 when the newest entry is in slot 0
//   dup          1-cycle pulse when a push was dropped as a repeat of the newest entry
// Optional feature: define MSG_HISTORY_DEDUP_EN to drop pushes equal to the newest entry.
module message_history #(
    parameter int STORE = 16,
    parameter int VIEW  = 5,
    parameter int CHARS = 16,
    parameter logic [CHARS*8-1:0] BLANK = "[     blank    ]"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [CHARS*8-1:0]      msg_in,
    input  logic                    clear,
    input  logic                    scroll_up,
    input  logic                    scroll_down,
    output logic [VIEW*CHARS*8-1:0] window,
    output logic [$clog2(STORE+1)-1:0] count,
    output logic                    live,
    output logic                    dup
);
    localparam int W  = CHARS * 8;
    localparam int AW = $clog2(STORE);
    localparam int CW = $clog2(STORE + 1);
    localparam logic [CW-1:0] FULL = CW'(STORE);
    localparam logic [CW-1:0] VW   = CW'(VIEW);

    logic [W-1:0]  mem [STORE];
    logic [AW-1:0] wptr;
    logic [CW-1:0] cnt, off, cnt_nx, off_nx, lim;
    logic          drop, acc;
    logic [VIEW*W-1:0] win_nx;
    logic [AW-1:0] idx;

`ifdef MSG_HISTORY_DEDUP_EN
    assign drop = push && cnt != '0 && msg_in == mem[wptr - AW'(1)];
`else
    assign drop = 1'b0;
`endif
    assign acc = push && !drop;

    // Push first, then scroll against the post-push count and offset.
    always_comb begin
        cnt_nx = acc ? (cnt == FULL ? cnt : cnt + CW'(1)) : cnt;
        lim    = cnt_nx > VW ? cnt_nx - VW : '0;
        off_nx = off;
        if (acc && off != '0)
            off_nx = off + CW'(1) < lim ? off + CW'(1) : lim;
        if (scroll_up && !scroll_down && cnt_nx > VW && off_nx < cnt_nx - VW)
            off_nx = off_nx + CW'(1);
        else if (scroll_down && !scroll_up && off_nx != '0)
            off_nx = off_nx - CW'(1);
    end

    always_comb begin
        win_nx = '0;
        idx    = '0;
        for (int k = 0; k < VIEW; k++) begin
            idx = wptr - AW'(1) - AW'(off) - AW'(k);
            win_nx[k*W +: W] = ({1'b0, off} + (CW+1)'(k)) < {1'b0, cnt} ? mem[idx] : BLANK;
        end
    end

    // Gated by reset so an asserted reset never lets a write land.
    always_ff @(posedge clk)
        if (acc && !clear && !reset)
            mem[wptr] <= msg_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            cnt    <= '0;
            off    <= '0;
            window <= {VIEW{BLANK}};
            count  <= '0;
            live   <= 1'b1;
            dup    <= 1'b0;
        end else begin
            window <= win_nx;
            count  <= cnt;
            live   <= off == '0;
            dup    <= drop && !clear;
            if (clear) begin
                wptr <= '0;
                cnt  <= '0;
                off  <= '0;
            end else begin
                wptr <= acc ? wptr + AW'(1) : wptr;
                cnt  <= cnt_nx;
                off  <= off_nx;
            end
        end
    end
endmodule
